// File: rtl/usb_rx_packet_pkg.sv
// Shared types and CRC helpers for the USB receive packet decoder.
package usb_rx_packet_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'h1,
    PID_ACK   = 4'h2,
    PID_DATA0 = 4'h3,
    PID_SOF   = 4'h5,
    PID_IN    = 4'h9,
    PID_NAK   = 4'hA,
    PID_DATA1 = 4'hB,
    PID_SETUP = 4'hD,
    PID_STALL = 4'hE
  } pid_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOK1,
    S_TOK2,
    S_TEND,
    S_DATA,
    S_HSK,
    S_ERR
  } state_t;

  localparam logic [4:0]  CRC5_POLY   = 5'h05;
  localparam logic [4:0]  CRC5_INIT   = 5'h1F;
  localparam logic [4:0]  CRC5_RESID  = 5'b01100;
  localparam logic [15:0] CRC16_POLY  = 16'h8005;
  localparam logic [15:0] CRC16_INIT  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESID = 16'h800D;

  // Bits are taken LSB first, matching the wire order.
  function automatic logic [4:0] crc5_step(
    input logic [4:0] c,
    input logic [7:0] d
  );
    logic [4:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[4] ^ d[i]) r = {r[3:0], 1'b0} ^ CRC5_POLY;
      else             r = {r[3:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] crc16_step(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ CRC16_POLY;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/usb_crc.sv
// Byte-wise CRC5/CRC16 accumulator with synchronous clear.
module usb_crc
  import usb_rx_packet_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [4:0]  crc5,
  output logic [15:0] crc16
);

  logic [4:0]  crc5_q, crc5_d;
  logic [15:0] crc16_q, crc16_d;

  always_comb begin
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    if (clr) begin
      crc5_d  = CRC5_INIT;
      crc16_d = CRC16_INIT;
    end else if (en) begin
      crc5_d  = crc5_step(crc5_q, din);
      crc16_d = crc16_step(crc16_q, din);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc5_q  <= CRC5_INIT;
      crc16_q <= CRC16_INIT;
    end else begin
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
    end
  end

  assign crc5  = crc5_q;
  assign crc16 = crc16_q;

endmodule

// File: rtl/usb_rx_packet.sv
// USB receive packet decoder: PID/token/data/handshake decode.
// Optional saturating error counter: define USB_RX_ERR_COUNT_EN.
module usb_rx_packet
  import usb_rx_packet_pkg::*;
#(
  parameter int MAX_PAYLOAD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_active,
  input  logic        rx_valid,
  input  logic        rx_error,
  input  logic [6:0]  dev_addr,
  output logic [3:0]  pid,
  output logic        token_valid,
  output logic [3:0]  token_endp,
  output logic [10:0] frame_no,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        data_done,
  output logic        hsk_valid,
  output logic        pkt_error,
  output logic [7:0]  err_count
);

  localparam int CW = $clog2(MAX_PAYLOAD + 3);
  localparam logic [CW-1:0] LEN_LIM = CW'(MAX_PAYLOAD + 2);
  localparam logic [CW-1:0] HOLD    = CW'(2);

  state_t state_q, state_d;
  logic act_q, armed_q, armed_d;
  logic [3:0] ptype_q, ptype_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] b0_q, b0_d, b1_q, b1_d;
  logic [3:0] pid_q, pid_d, endp_q, endp_d;
  logic [10:0] frame_q, frame_d;
  logic [7:0] dout_q, dout_d;
  logic tok_q, tok_d, dv_q, dv_d;
  logic done_q, done_d, hsk_q, hsk_d;
  logic perr_q, perr_d;
  logic [4:0] crc5;
  logic [15:0] crc16;

  logic eop, byte_in, err_in, len_err, shift;
  logic pid_ok, is_tok, is_data, is_hsk;
  logic [3:0] pn;

  assign eop     = act_q & ~rx_active;
  assign byte_in = rx_valid & rx_active;
  assign err_in  = rx_error & rx_active;
  assign len_err = (cnt_q == LEN_LIM);
  assign shift   = byte_in & ~err_in &
                   ((state_q == S_TOK1) | (state_q == S_TOK2) |
                    ((state_q == S_DATA) & ~len_err));

  assign pn      = rx_data[3:0];
  assign pid_ok  = (rx_data[7:4] == ~rx_data[3:0]);
  assign is_tok  = pid_ok & ((pn == PID_OUT) | (pn == PID_IN) |
                             (pn == PID_SETUP) | (pn == PID_SOF));
  assign is_data = pid_ok & ((pn == PID_DATA0) | (pn == PID_DATA1));
  assign is_hsk  = pid_ok & ((pn == PID_ACK) | (pn == PID_NAK) |
                             (pn == PID_STALL));

  usb_crc u_crc (
    .clk   (clk),
    .rst   (reset),
    .clr   (state_q == S_IDLE),
    .en    (shift),
    .din   (rx_data),
    .crc5  (crc5),
    .crc16 (crc16)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // The PID byte is classified as it arrives in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (armed_q && err_in) state_d = S_ERR;
        else if (armed_q && byte_in) begin
          unique case (1'b1)
            is_tok:  state_d = S_TOK1;
            is_data: state_d = S_DATA;
            is_hsk:  state_d = S_HSK;
            default: state_d = S_ERR;
          endcase
        end
      end
      S_TOK1: begin
        if (err_in)       state_d = S_ERR;
        else if (byte_in) state_d = S_TOK2;
        else if (eop)     state_d = S_IDLE;
      end
      S_TOK2: begin
        if (err_in)       state_d = S_ERR;
        else if (byte_in) state_d = S_TEND;
        else if (eop)     state_d = S_IDLE;
      end
      S_DATA: begin
        if (err_in || (byte_in && len_err)) state_d = S_ERR;
        else if (eop) state_d = S_IDLE;
      end
      S_TEND, S_HSK: begin
        if (err_in || byte_in) state_d = S_ERR;
        else if (eop)          state_d = S_IDLE;
      end
      S_ERR: begin
        if (eop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    armed_d = armed_q | ~rx_active;
    ptype_d = ptype_q;
    cnt_d   = cnt_q;
    b0_d    = b0_q;
    b1_d    = b1_q;
    pid_d   = pid_q;
    endp_d  = endp_q;
    frame_d = frame_q;
    dout_d  = dout_q;
    tok_d   = 1'b0;
    dv_d    = 1'b0;
    done_d  = 1'b0;
    hsk_d   = 1'b0;
    perr_d  = 1'b0;
    if (state_q == S_IDLE && armed_q && byte_in) begin
      ptype_d = pn;
      cnt_d   = '0;
    end
    // Two-byte holdoff keeps the CRC16 bytes from ever being delivered.
    if (shift) begin
      b0_d  = b1_q;
      b1_d  = rx_data;
      cnt_d = cnt_q + 1'b1;
      if (state_q == S_DATA && cnt_q >= HOLD) begin
        dout_d = b0_q;
        dv_d   = 1'b1;
      end
    end
    if (eop) begin
      unique case (state_q)
        S_TEND: begin
          if (crc5 != CRC5_RESID) perr_d = 1'b1;
          else if (ptype_q == PID_SOF) begin
            tok_d   = 1'b1;
            pid_d   = ptype_q;
            frame_d = {b1_q[2:0], b0_q};
          end else if (b0_q[6:0] == dev_addr) begin
            tok_d   = 1'b1;
            pid_d   = ptype_q;
            endp_d  = {b1_q[2:0], b0_q[7]};
          end
        end
        S_TOK1, S_TOK2, S_ERR: perr_d = 1'b1;
        S_DATA: begin
          if (cnt_q >= HOLD && crc16 == CRC16_RESID) begin
            done_d = 1'b1;
            pid_d  = ptype_q;
          end else perr_d = 1'b1;
        end
        S_HSK: begin
          hsk_d = 1'b1;
          pid_d = ptype_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q   <= 1'b0;
      armed_q <= 1'b0;
      ptype_q <= '0;
      cnt_q   <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      pid_q   <= '0;
      endp_q  <= '0;
      frame_q <= '0;
      dout_q  <= '0;
      tok_q   <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
      hsk_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      act_q   <= rx_active;
      armed_q <= armed_d;
      ptype_q <= ptype_d;
      cnt_q   <= cnt_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
      pid_q   <= pid_d;
      endp_q  <= endp_d;
      frame_q <= frame_d;
      dout_q  <= dout_d;
      tok_q   <= tok_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      hsk_q   <= hsk_d;
      perr_q  <= perr_d;
    end
  end

`ifdef USB_RX_ERR_COUNT_EN
  logic [7:0] errc_q, errc_d;
  always_comb begin
    errc_d = errc_q;
    if (perr_d && errc_q != 8'hFF) errc_d = errc_q + 8'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) errc_q <= '0;
    else       errc_q <= errc_d;
  end
  assign err_count = errc_q;
`else
  assign err_count = 8'h00;
`endif

  assign pid         = pid_q;
  assign token_valid = tok_q;
  assign token_endp  = endp_q;
  assign frame_no    = frame_q;
  assign data_out    = dout_q;
  assign data_valid  = dv_q;
  assign data_done   = done_q;
  assign hsk_valid   = hsk_q;
  assign pkt_error   = perr_q;

endmodule

// File: tb/tb_usb_rx_packet.sv
// Directed self-checking bench for usb_rx_packet.
module tb_usb_rx_packet;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_active, rx_valid, rx_error;
  logic [6:0]  dev_addr;
  logic [3:0]  pid, token_endp;
  logic        token_valid, data_valid, data_done, hsk_valid, pkt_error;
  logic [10:0] frame_no;
  logic [7:0]  data_out, err_count;

  usb_rx_packet dut (
    .clk         (clk),
    .reset       (reset),
    .rx_data     (rx_data),
    .rx_active   (rx_active),
    .rx_valid    (rx_valid),
    .rx_error    (rx_error),
    .dev_addr    (dev_addr),
    .pid         (pid),
    .token_valid (token_valid),
    .token_endp  (token_endp),
    .frame_no    (frame_no),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_done   (data_done),
    .hsk_valid   (hsk_valid),
    .pkt_error   (pkt_error),
    .err_count   (err_count)
  );

  always #20 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, fall_cyc = 0, tok_cyc = 0;
  int n_tok = 0, n_dv = 0, n_done = 0, n_hsk = 0, n_err = 0;
  int b_tok, b_dv, b_done, b_hsk, b_err;
  logic [7:0] got [0:1023];
  logic [7:0] pb [0:31];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (token_valid) begin
      n_tok   <= n_tok + 1;
      tok_cyc <= cyc;
    end
    if (data_valid) begin
      got[n_dv % 1024] <= data_out;
      n_dv <= n_dv + 1;
    end
    if (data_done) n_done <= n_done + 1;
    if (hsk_valid) n_hsk  <= n_hsk + 1;
    if (pkt_error) n_err  <= n_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_tok = n_tok; b_dv = n_dv; b_done = n_done;
    b_hsk = n_hsk; b_err = n_err;
  endtask

  task automatic pulses(input string tag, input int t, input int dv,
                        input int dn, input int hk, input int er);
    chk({tag, ".tok"},  n_tok - b_tok, t);
    chk({tag, ".dv"},   n_dv - b_dv, dv);
    chk({tag, ".done"}, n_done - b_done, dn);
    chk({tag, ".hsk"},  n_hsk - b_hsk, hk);
    chk({tag, ".err"},  n_err - b_err, er);
  endtask

  task automatic load(input logic [255:0] v, input int n);
    for (int i = 0; i < n; i++) pb[i] = v[8*(n-1-i) +: 8];
  endtask

  task automatic send(input int n, input int err_at);
    snap();
    rx_active = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      rx_data  = pb[i];
      rx_valid = 1'b1;
      rx_error = (i == err_at);
      @(negedge clk);
      rx_valid = 1'b0;
      rx_error = 1'b0;
      repeat (3) @(negedge clk);
    end
    rx_active = 1'b0;
    fall_cyc  = cyc;
    repeat (5) @(negedge clk);
  endtask

  function automatic logic [4:0] crc5_tx(input logic [10:0] d);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      if (c[4] ^ d[i]) c = {c[3:0], 1'b0} ^ 5'h05;
      else             c = {c[3:0], 1'b0};
    end
    return ~c;
  endfunction

  logic [63:0] exp_pl;
  logic [4:0]  sc;
  logic [10:0] fr;

  initial begin
    reset = 1'b1; rx_data = '0; rx_active = 1'b0;
    rx_valid = 1'b0; rx_error = 1'b0; dev_addr = 7'd0;
    repeat (3) @(negedge clk);
    chk("reset.outs", {pid, token_valid, token_endp, frame_no, data_out,
        data_valid, data_done, hsk_valid, pkt_error}, 32'd0);
    chk("reset.errc", err_count, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    load({8'h2D, 8'h00, 8'h10}, 3);
    send(3, -1);
    pulses("setup_tok", 1, 0, 0, 0, 0);
    chk("setup_tok.pid", pid, 4'hD);
    chk("setup_tok.endp", token_endp, 4'h0);
    chk("setup_tok.lat", tok_cyc - fall_cyc, 1);

    load({8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00,
          8'h40, 8'h00, 8'hDD, 8'h94}, 11);
    send(11, -1);
    pulses("data8", 0, 8, 1, 0, 0);
    exp_pl = 64'h8006000100004000;
    for (int i = 0; i < 8; i++)
      chk($sformatf("data8.b%0d", i), got[(b_dv + i) % 1024],
          exp_pl[8*(7-i) +: 8]);
    chk("data8.pid", pid, 4'h3);

    load({8'h4B, 8'h00, 8'h00}, 3);
    send(3, -1);
    pulses("zlp", 0, 0, 1, 0, 0);
    chk("zlp.pid", pid, 4'hB);

    load({8'hD2}, 1);
    send(1, -1);
    pulses("ack", 0, 0, 0, 1, 0);
    chk("ack.pid", pid, 4'h2);

    load({8'h21}, 1);
    send(1, -1);
    pulses("badpid", 0, 0, 0, 0, 1);
    chk("badpid.pid", pid, 4'h2);

    load({8'h2D, 8'h00, 8'h11}, 3);
    send(3, -1);
    pulses("badcrc5", 0, 0, 0, 0, 1);

    dev_addr = 7'd1;
    load({8'h2D, 8'h00, 8'h10}, 3);
    send(3, -1);
    pulses("addr_miss", 0, 0, 0, 0, 0);
    dev_addr = 7'd0;

    fr = 11'h27A;
    sc = crc5_tx(fr);
    load({8'hA5, fr[7:0], sc[0], sc[1], sc[2], sc[3], sc[4], fr[10:8]}, 3);
    send(3, -1);
    pulses("sof", 1, 0, 0, 0, 0);
    chk("sof.frame", frame_no, 11'h27A);
    chk("sof.endp", token_endp, 4'h0);
    chk("sof.pid", pid, 4'h5);

    load({8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
          8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'hAA, 8'hBB}, 15);
    send(15, -1);
    pulses("toolong", 0, 8, 0, 0, 1);
    chk("toolong.last", got[(b_dv + 7) % 1024], 8'h08);

    load({8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00,
          8'h40, 8'h00, 8'hDD, 8'h94}, 11);
    send(11, 4);
    chk("rxerr.done", n_done - b_done, 0);
    chk("rxerr.err", n_err - b_err, 1);

    load({8'hC3, 8'h00}, 2);
    send(2, -1);
    pulses("shortdata", 0, 0, 0, 0, 1);

    load({8'h2D, 8'h00}, 2);
    send(2, -1);
    pulses("shorttok", 0, 0, 0, 0, 1);

    load({8'hD2, 8'h00}, 2);
    send(2, -1);
    pulses("longhsk", 0, 0, 0, 0, 1);

`ifndef USB_RX_ERR_COUNT_EN
    chk("errc.off", err_count, 8'h00);
`endif

    snap();
    rx_active = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_data = (i == 0) ? 8'hC3 : 8'(i); rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midrst.outs", {pid, token_valid, token_endp, frame_no, data_out,
        data_valid, data_done, hsk_valid, pkt_error}, 32'd0);
    chk("midrst.errc", err_count, 8'h00);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rx_data = 8'h55; rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    rx_active = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst.quiet", (n_tok - b_tok) + (n_done - b_done) +
        (n_hsk - b_hsk) + (n_err - b_err), 0);

    load({8'h2D, 8'h00, 8'h10}, 3);
    send(3, -1);
    pulses("postrst", 1, 0, 0, 0, 0);
    chk("postrst.pid", pid, 4'hD);

`ifdef USB_RX_ERR_COUNT_EN
    load({8'h21}, 1);
    for (int i = 0; i < 5; i++) send(1, -1);
    chk("errc.5", err_count, 8'h05);
    for (int i = 0; i < 295; i++) send(1, -1);
    chk("errc.sat", err_count, 8'hFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/usb_rx_packet.md
Name: usb_rx_packet

Overview:
- Receive-side packet decoder directly downstream of usb_transceiver.
- Consumes the transceiver's byte stream (rx_data/rx_active/rx_valid/rx_error) and performs four tasks:
  - PID validation.
  - Token decoding with CRC5 check and address match.
  - Data payload delivery with the CRC16 bytes stripped and checked.
  - Handshake recognition.
- Feeds the SIE endpoint logic. Runs in the 24 MHz clk domain.

Parameters:
MAX_PAYLOAD, 8, maximum data-payload bytes (low speed); more bytes is a length error.

Ports:
clk  in  1  system clock, 24 MHz
reset  in  1  asynchronous reset, active-high
rx_data  in  8  byte from usb_transceiver
rx_active  in  1  high between SYNC and EOP
rx_valid  in  1  one-clk pulse, rx_data valid
rx_error  in  1  transceiver error (bit-stuff/EOP)
dev_addr  in  7  assigned device address
pid  out  4  PID[3:0] of last packet with valid PID check
token_valid  out  1  pulse: good token (OUT/IN/SETUP matching dev_addr, or any SOF)
token_endp  out  4  endpoint of last good token
frame_no  out  11  frame number of last good SOF
data_out  out  8  payload byte
data_valid  out  1  pulse, data_out valid
data_done  out  1  pulse: data packet ended, CRC16 good
hsk_valid  out  1  pulse: ACK/NAK/STALL received
pkt_error  out  1  pulse: packet rejected
err_count  out  8  saturating error count (optional feature)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Async reset mid-packet aborts it with no pulses; after reset, wait for rx_active low before decoding.
- Bit order: bytes arrive LSB first, and both CRCs are computed LSB first.
- CRC5:
  - Polynomial x^5+x^2+1, init 5'h1F.
  - Computed over 16 bits (addr[6:0], endp[3:0], crc[4:0]).
  - Good when the residual is 5'b01100.
- CRC16:
  - Polynomial 0x8005, init 16'hFFFF.
  - Computed over payload plus 2 CRC bytes.
  - Good when the residual is 16'h800D.
- PID check: byte0[7:4] must equal ~byte0[3:0], otherwise error.
- FSM states and transitions:
  - IDLE: first rx_valid while rx_active goes to PID handling.
  - PID: token PIDs (OUT 1, IN 9, SETUP D, SOF 5) go to TOK1; DATA0/DATA1 (3, B) go to DATA; ACK/NAK/STALL (2, A, E) go to HSK; any other or failed check goes to ERR.
  - TOK1: one byte goes to TOK2.
  - TOK2: one byte goes to TEND.
  - TEND: a further byte goes to ERR.
  - DATA: bytes are shifted through the 2-byte holdoff buffer.
  - HSK: any further byte goes to ERR.
  - ERR: wait for rx_active low; emit pkt_error on its falling edge.
- End of packet (rx_active 1→0), acted on in the next clk:
  - TEND: CRC5 good and (SOF or addr==dev_addr) pulses token_valid and updates token_endp/frame_no/pid. CRC5 bad pulses pkt_error. Address mismatch is dropped silently.
  - TOK1/TOK2 (short token) pulses pkt_error.
  - DATA with fewer than 2 bytes after PID pulses pkt_error.
  - DATA with CRC16 good pulses data_done. CRC16 bad pulses pkt_error.
  - HSK pulses hsk_valid.
- Payload delivery:
  - Byte n of the payload is emitted on data_valid only when byte n+2 arrives, one clk after that rx_valid. The CRC bytes are therefore never emitted.
  - The SIE discards the delivered bytes if pkt_error follows instead of data_done.
- Length error: a (MAX_PAYLOAD+3)th byte after the PID goes to ERR. Bytes already emitted stand.
- rx_error while rx_active, in any state, goes to ERR.
- Exactly one of token_valid/data_done/hsk_valid/pkt_error per packet, or none for address mismatch.
- Decoder accepts back-to-back packets; IDLE is re-entered in the cycle the end-of-packet pulse is issued.

Optional Feature:
- USB_RX_ERR_COUNT_EN:
  - Defined: err_count increments on each pkt_error and saturates at 8'hFF. Cleared only by reset.
  - Undefined: err_count is tied to 8'h00 and no counter logic exists.

Decomposition:
- Package types gains:
  - pid_t enum (4-bit PIDs).
  - CRC5/CRC16 polynomial, init and residual constants.
  - crc5_step/crc16_step byte-update functions.
- One sub-module, usb_crc, accumulates CRC5 and CRC16 per byte with a clear input.
- FSM and holdoff buffer stay in usb_rx_packet.

Test Plan:
- dev_addr=0, bytes 2D 00 10 → token_valid 1 clk after rx_active falls, pid=4'hD, token_endp=0, no pkt_error.
- dev_addr=0, bytes C3 80 06 00 01 00 00 40 00 DD 94 → data_out 80,06,00,01,00,00,40,00 on 8 data_valid pulses, then data_done. The DD/94 bytes are never output.
- Bytes 4B 00 00 → data_done with zero data_valid pulses; pid=4'hB.
- Bytes D2 → hsk_valid; bytes 21 → pkt_error, pid unchanged.
- Corruptions:
  - 2D 00 11 gives pkt_error.
  - dev_addr=1 with 2D 00 10 gives no output pulse.
  - 12 payload bytes gives pkt_error.
  - rx_error mid-DATA gives pkt_error at end.
- With USB_RX_ERR_COUNT_EN: 300 bad packets → err_count=8'hFF. Reset asserted mid-DATA → all outputs 0 and the next good packet decodes.
